proc: RTL and testbench
=======================

PROC -- requirements
Module: proc

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 512: instruction-memory words, addressed by 9-bit a and the 9-bit PC.
REQ-002 SHALL have parameter DMEM_DEPTH, default 512: data-memory words, 9-bit address taken from the low bits of the computed address.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port a, input, 9: instruction-memory load address.
REQ-006 SHALL have port d, input, 32: instruction-memory load data.
REQ-007 SHALL have port we, input, 1: load strobe, writes d to imem[a].
REQ-008 SHALL have port exec, input, 1: run enable; 1 = execute, 0 = load/pause.
REQ-009 SHALL have ports out1, out2, out3, out4, output, 32 each: combinational copies of registers $19, $20, $21, $22.

Function
REQ-010 SHALL, while exec=0 and we=1, write imem[a]<=d on each clock edge; we SHALL be ignored while exec=1.
REQ-011 SHALL, while exec=1 and not halted, execute exactly one instruction per clock edge (single-cycle): fetch imem[PC], read registers combinationally, commit register, data-memory and PC updates on the edge.
REQ-012 SHALL, while exec=0, hold PC, registers and data memory.
REQ-013 SHALL have separate instruction and data memories; data memory SHALL be read asynchronously and written synchronously.
REQ-014 SHALL keep $0 at zero; writes to $0 SHALL be discarded.
REQ-015 SHALL decode opcode [31:26]; fields F1=[25:21], F2=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=[15:0], target=[25:0].
REQ-016 SHALL implement R-type (opcode 0): add funct 32 rd=F1+F2; sub funct 34 rd=F1-F2; and funct 36; or funct 37; slt funct 42 (signed, result 1/0); sll funct 0 rd=F1<<shamt; srl funct 2 rd=F1>>shamt (logical).
REQ-017 SHALL implement addi opcode 8: reg[F2]=reg[F1]+sext(imm); andi opcode 12 and ori opcode 13: reg[F2]=reg[F1] AND/OR zext(imm).
REQ-018 SHALL implement lui opcode 36: reg[F1]={imm,16'h0}.
REQ-019 SHALL implement lw opcode 35: reg[F1]=dmem[reg[F2]+sext(imm)]; sw opcode 43: dmem[reg[F2]+sext(imm)]=reg[F1].
REQ-020 SHALL implement signed branches comparing reg[F1] with reg[F2]: ble opcode 0x32 taken if F1<F2; bgte 0x33 if F1>=F2; bleq 0x34 if F1<=F2; taken target PC+1+sext(imm), else PC+1.
REQ-021 SHALL implement j opcode 1: PC=target[8:0].
REQ-022 SHALL treat instruction word 32'h00000000 as HALT: PC holds, no state changes until reset; any other unlisted opcode/funct SHALL be a no-op with PC+1.
REQ-023 SHALL wrap PC modulo 512; arithmetic SHALL be 32-bit two's complement with overflow ignored.

Reset
REQ-024 SHALL, on rst=1, asynchronously clear PC to 0, all 32 registers to 0, all data memory to 0, all instruction memory to 0, and the halt flag; out1..out4 SHALL read 0.
REQ-025 SHALL, on rst asserted mid-execution, abort immediately, with no partial write committed on the next edge while rst=1.

Verification
REQ-026 Load the 46-word insertion-sort program (stores 5,3,9,7 to dmem[13..16], sorts, loads to $19..$22), then exec=1 -> after halt at PC 46, out1..out4 = 3,5,7,9 and they stay stable.
REQ-027 imem[0]=addi $1,$0,-1 (F1=0,F2=1), imem[1]=lui F1=19 imm 0x1234, imem[2]=0 -> $1=0xFFFFFFFF, out1=0x12340000, PC holds at 2.
REQ-028 bgte with reg[F1]=1, reg[F2]=4, imm=21 at PC 20 -> not taken, next PC 21; with reg[F1]=4 -> PC 42; ble with -1 vs 0 -> taken.
REQ-029 we=1 with exec=1 on a, d -> imem unchanged; exec dropped mid-run -> registers and PC frozen, resume continues identically.
REQ-030 addi writing F2=0 with imm 5 -> $0 reads 0; rst pulse mid-sort -> out1..out4 = 0 and PC = 0 immediately.

Source files
------------

// File: rtl/proc.sv
// rtl/proc.sv - single-cycle 32-bit processor with loadable instruction memory
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous active-high reset; clears PC, registers,
//                both memories and the halt state
//   a[8:0]     : instruction-memory load address
//   d[31:0]    : instruction-memory load data
//   we         : load strobe, writes d to imem[a] only while exec=0
//   exec       : 1 = execute one instruction per clock, 0 = load/pause
//   out1..out4 : combinational copies of registers $19..$22

module proc #(
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  a,
    input  logic [31:0] d,
    input  logic        we,
    input  logic        exec,
    output logic [31:0] out1,
    output logic [31:0] out2,
    output logic [31:0] out3,
    output logic [31:0] out4
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd1;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_LUI   = 6'd36;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BLE   = 6'h32;
    localparam logic [5:0] OP_BGTE  = 6'h33;
    localparam logic [5:0] OP_BLEQ  = 6'h34;

    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_SRL   = 6'd2;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_SLT   = 6'd42;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    // Architectural state
    logic [31:0] r_imem [IMEM_DEPTH];
    logic [31:0] r_dmem [DMEM_DEPTH];
    logic [31:0] r_regs [32];
    logic [8:0]  r_pc;
    state_t      r_state;
    state_t      w_state_next;

    // Fetch and decode
    logic [31:0] w_instr;
    logic [5:0]  w_op;
    logic [4:0]  w_f1;
    logic [4:0]  w_f2;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [25:0] w_target;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_sext;
    logic [31:0] w_zext;
    logic [31:0] w_ea;
    logic [31:0] w_ld_data;
    logic [8:0]  w_pc_inc;
    logic [8:0]  w_pc_br;
    logic        w_lt;
    logic        w_is_halt;
    logic        w_step;

    // Commit controls
    logic        w_reg_we;
    logic [4:0]  w_reg_waddr;
    logic [31:0] w_reg_wdata;
    logic        w_mem_we;
    logic [8:0]  w_pc_next;

    logic        w_unused;

    assign w_instr   = r_imem[r_pc];
    assign w_op      = w_instr[31:26];
    assign w_f1      = w_instr[25:21];
    assign w_f2      = w_instr[20:16];
    assign w_rd      = w_instr[15:11];
    assign w_shamt   = w_instr[10:6];
    assign w_funct   = w_instr[5:0];
    assign w_imm     = w_instr[15:0];
    assign w_target  = w_instr[25:0];

    assign w_a       = r_regs[w_f1];
    assign w_b       = r_regs[w_f2];
    assign w_sext    = {{16{w_imm[15]}}, w_imm};
    assign w_zext    = {16'h0000, w_imm};
    assign w_ea      = w_b + w_sext;
    assign w_ld_data = r_dmem[w_ea[8:0]];
    assign w_pc_inc  = r_pc + 9'd1;
    // Low 9 bits of the sign-extended offset are enough: PC wraps mod 512
    assign w_pc_br   = w_pc_inc + w_imm[8:0];
    assign w_lt      = $signed(w_a) < $signed(w_b);

    // An all-zero word halts; nothing else commits on that edge
    assign w_is_halt = (w_instr == 32'h0000_0000);
    assign w_step    = exec && (r_state == S_RUN) && !w_is_halt;

    // Address/target bits above the 9-bit memory range are dropped on purpose
    assign w_unused  = ^{w_ea[31:9], w_target[25:9]};

    always_comb begin
        w_reg_we    = 1'b0;
        w_reg_waddr = w_rd;
        w_reg_wdata = 32'h0000_0000;
        w_mem_we    = 1'b0;
        w_pc_next   = w_pc_inc;
        case (w_op)
            OP_RTYPE: begin
                w_reg_waddr = w_rd;
                w_reg_we    = 1'b1;
                case (w_funct)
                    FN_ADD:  w_reg_wdata = w_a + w_b;
                    FN_SUB:  w_reg_wdata = w_a - w_b;
                    FN_AND:  w_reg_wdata = w_a & w_b;
                    FN_OR:   w_reg_wdata = w_a | w_b;
                    FN_SLT:  w_reg_wdata = {31'd0, w_lt};
                    FN_SLL:  w_reg_wdata = w_a << w_shamt;
                    FN_SRL:  w_reg_wdata = w_a >> w_shamt;
                    default: w_reg_we    = 1'b0;
                endcase
            end
            OP_ADDI: begin
                w_reg_we    = 1'b1;
                w_reg_waddr = w_f2;
                w_reg_wdata = w_a + w_sext;
            end
            OP_ANDI: begin
                w_reg_we    = 1'b1;
                w_reg_waddr = w_f2;
                w_reg_wdata = w_a & w_zext;
            end
            OP_ORI: begin
                w_reg_we    = 1'b1;
                w_reg_waddr = w_f2;
                w_reg_wdata = w_a | w_zext;
            end
            OP_LUI: begin
                w_reg_we    = 1'b1;
                w_reg_waddr = w_f1;
                w_reg_wdata = {w_imm, 16'h0000};
            end
            OP_LW: begin
                w_reg_we    = 1'b1;
                w_reg_waddr = w_f1;
                w_reg_wdata = w_ld_data;
            end
            OP_SW: begin
                w_mem_we    = 1'b1;
            end
            OP_BLE: begin
                if (w_lt) w_pc_next = w_pc_br;
            end
            OP_BGTE: begin
                if (!w_lt) w_pc_next = w_pc_br;
            end
            OP_BLEQ: begin
                if (w_lt || (w_a == w_b)) w_pc_next = w_pc_br;
            end
            OP_J: begin
                w_pc_next   = w_target[8:0];
            end
            default: ;
        endcase
    end

    // Halt is sticky until reset, even if imem is reloaded afterwards
    always_comb begin
        w_state_next = r_state;
        if ((r_state == S_RUN) && exec && w_is_halt) begin
            w_state_next = S_HALT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= 9'd0;
        end else if (w_step) begin
            r_pc <= w_pc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'h0000_0000;
        end else if (w_step && w_reg_we && (w_reg_waddr != 5'd0)) begin
            r_regs[w_reg_waddr] <= w_reg_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DMEM_DEPTH; i++) r_dmem[i] <= 32'h0000_0000;
        end else if (w_step && w_mem_we) begin
            r_dmem[w_ea[8:0]] <= w_a;
        end
    end

    // Loading is only possible while paused
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IMEM_DEPTH; i++) r_imem[i] <= 32'h0000_0000;
        end else if (!exec && we) begin
            r_imem[a] <= d;
        end
    end

    assign out1 = r_regs[19];
    assign out2 = r_regs[20];
    assign out3 = r_regs[21];
    assign out4 = r_regs[22];

endmodule

// File: tb/tb_proc.sv
// tb/tb_proc.sv - self-checking bench for proc with ISA-level reference model

module tb_proc;

    logic        clk;
    logic        rst;
    logic [8:0]  a;
    logic [31:0] d;
    logic        we;
    logic        exec;
    logic [31:0] out1, out2, out3, out4;

    proc dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .d    (d),
        .we   (we),
        .exec (exec),
        .out1 (out1),
        .out2 (out2),
        .out3 (out3),
        .out4 (out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: instruction-level interpreter
    logic [31:0] m_imem [512];
    logic [31:0] m_dmem [512];
    logic [31:0] m_regs [32];
    int          m_pc;
    bit          m_halt;

    logic [31:0] prog [$];

    localparam logic [31:0] NOP = 32'h0000_0025;

    function automatic logic [31:0] enc_r(input logic [4:0] f1, input logic [4:0] f2,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'd0, f1, f2, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] f1,
                                          input logic [4:0] f2, input logic [15:0] imm);
        return {op, f1, f2, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] t);
        return {6'd1, t};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 512; i++) begin
            m_imem[i] = 0;
            m_dmem[i] = 0;
        end
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        m_pc   = 0;
        m_halt = 0;
    endtask

    task automatic wr(input int idx, input logic [31:0] val);
        if (idx != 0) m_regs[idx] = val;
    endtask

    task automatic model_step();
        logic [31:0] ins, va, vb, se, ze, ea;
        int op, f1, f2, rd, sh, fn, simm, nxt;
        if (rst) return;
        if (!exec) begin
            if (we) m_imem[a] = d;
            return;
        end
        if (m_halt) return;
        ins = m_imem[m_pc];
        if (ins == 0) begin
            m_halt = 1;
            return;
        end
        op   = int'(ins[31:26]);
        f1   = int'(ins[25:21]);
        f2   = int'(ins[20:16]);
        rd   = int'(ins[15:11]);
        sh   = int'(ins[10:6]);
        fn   = int'(ins[5:0]);
        simm = int'($signed(ins[15:0]));
        se   = 32'(simm);
        ze   = 32'(int'(ins[15:0]));
        va   = m_regs[f1];
        vb   = m_regs[f2];
        ea   = vb + se;
        nxt  = (m_pc + 1) & 511;
        case (op)
            0: case (fn)
                32: wr(rd, va + vb);
                34: wr(rd, va - vb);
                36: wr(rd, va & vb);
                37: wr(rd, va | vb);
                42: wr(rd, (int'(va) < int'(vb)) ? 32'd1 : 32'd0);
                0:  wr(rd, va << sh);
                2:  wr(rd, va >> sh);
                default: ;
            endcase
            8:  wr(f2, va + se);
            12: wr(f2, va & ze);
            13: wr(f2, va | ze);
            36: wr(f1, ze * 65536);
            35: wr(f1, m_dmem[ea % 512]);
            43: m_dmem[ea % 512] = va;
            50: if (int'(va) <  int'(vb)) nxt = (m_pc + 1 + simm) & 511;
            51: if (int'(va) >= int'(vb)) nxt = (m_pc + 1 + simm) & 511;
            52: if (int'(va) <= int'(vb)) nxt = (m_pc + 1 + simm) & 511;
            1:  nxt = int'(ins[25:0]) % 512;
            default: ;
        endcase
        m_pc = nxt;
    endtask

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_state(input string nm);
        string why;
        why = "";
        if (32'(dut.r_pc) !== 32'(m_pc))
            why = $sformatf("pc got %0d expected %0d", dut.r_pc, m_pc);
        for (int k = 0; k < 32; k++)
            if (why == "" && dut.r_regs[k] !== m_regs[k])
                why = $sformatf("reg %0d got %h expected %h", k, dut.r_regs[k], m_regs[k]);
        if (why == "" && {out1, out2, out3, out4} !== {m_regs[19], m_regs[20], m_regs[21], m_regs[22]})
            why = $sformatf("outs got %h %h %h %h", out1, out2, out3, out4);
        n_tests++;
        if (why != "") begin
            n_fail++;
            $display("FAIL %s: %s", nm, why);
        end
    endtask

    // Inputs are set at the falling edge; the model commits with the same inputs
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exec = 1'b0;
        we = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_prog();
        exec = 1'b0;
        for (int i = 0; i < prog.size(); i++) begin
            a  = 9'(i);
            d  = prog[i];
            we = 1'b1;
            tick();
        end
        we = 1'b0;
    endtask

    task automatic run(input int n);
        exec = 1'b1;
        we   = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Random exec pauses and ignored load noise, lockstep compared every cycle
    task automatic run_noisy(input string nm, input int bound);
        int t;
        t = 0;
        while (!m_halt && t < bound) begin
            exec = ($urandom_range(0, 3) != 0);
            we   = exec ? 1'($urandom_range(0, 1)) : 1'b0;
            a    = 9'($urandom_range(0, 511));
            d    = $urandom;
            tick();
            check_state(nm);
            t++;
        end
        n_tests++;
        if (!m_halt) begin
            n_fail++;
            $display("FAIL %s_timeout: got no halt within %0d cycles, required halt", nm, bound);
        end
        exec = 1'b0;
        we   = 1'b0;
    endtask

    task automatic build_sort();
        prog.delete();
        prog.push_back(enc_i(8, 0, 1, 5));   prog.push_back(enc_i(43, 1, 0, 13));
        prog.push_back(enc_i(8, 0, 1, 3));   prog.push_back(enc_i(43, 1, 0, 14));
        prog.push_back(enc_i(8, 0, 1, 9));   prog.push_back(enc_i(43, 1, 0, 15));
        prog.push_back(enc_i(8, 0, 1, 7));   prog.push_back(enc_i(43, 1, 0, 16));
        prog.push_back(enc_i(8, 0, 2, 1));                  // 8  i = 1
        prog.push_back(enc_i(8, 0, 4, 4));                  // 9  n = 4
        prog.push_back(enc_i(6'h33, 2, 4, 11));             // 10 i >= n -> 22
        prog.push_back(enc_i(35, 5, 2, 13));                // 11 key = a[i]
        prog.push_back(enc_i(8, 2, 3, 16'hFFFF));           // 12 j = i - 1
        prog.push_back(enc_i(6'h32, 3, 0, 5));              // 13 j < 0 -> 19
        prog.push_back(enc_i(35, 6, 3, 13));                // 14 t = a[j]
        prog.push_back(enc_i(6'h34, 6, 5, 3));              // 15 t <= key -> 19
        prog.push_back(enc_i(43, 6, 3, 14));                // 16 a[j+1] = t
        prog.push_back(enc_i(8, 3, 3, 16'hFFFF));           // 17 j--
        prog.push_back(enc_j(13));                          // 18
        prog.push_back(enc_i(43, 5, 3, 14));                // 19 a[j+1] = key
        prog.push_back(enc_i(8, 2, 2, 1));                  // 20 i++
        prog.push_back(enc_j(10));                          // 21
        prog.push_back(enc_i(35, 19, 0, 13));  prog.push_back(enc_i(35, 20, 0, 14));
        prog.push_back(enc_i(35, 21, 0, 15));  prog.push_back(enc_i(35, 22, 0, 16));
        while (prog.size() < 46) prog.push_back(NOP);
    endtask

    typedef struct {
        string       name;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] instr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [15];

    logic [4:0] regset [9];
    logic [5:0] fnset  [8];

    function automatic logic [4:0] rr();
        return regset[$urandom_range(0, 8)];
    endfunction

    initial begin
        regset = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd19, 5'd20, 5'd21, 5'd22};
        fnset  = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0, 6'd2, 6'd63};

        vecs[0]  = '{"add",      32'd5,        32'd7,        enc_r(1, 2, 3, 0, 32),         32'd12};
        vecs[1]  = '{"add_ovf",  32'h7FFFFFFF, 32'd1,        enc_r(1, 2, 3, 0, 32),         32'h80000000};
        vecs[2]  = '{"sub_neg",  32'd3,        32'd5,        enc_r(1, 2, 3, 0, 34),         32'hFFFFFFFE};
        vecs[3]  = '{"and",      32'hF0F0F0F0, 32'hFF00FF00, enc_r(1, 2, 3, 0, 36),         32'hF000F000};
        vecs[4]  = '{"or",       32'h0F0F0000, 32'h000000FF, enc_r(1, 2, 3, 0, 37),         32'h0F0F00FF};
        vecs[5]  = '{"slt_t",    32'hFFFFFFFF, 32'd1,        enc_r(1, 2, 3, 0, 42),         32'd1};
        vecs[6]  = '{"slt_f",    32'd1,        32'hFFFFFFFF, enc_r(1, 2, 3, 0, 42),         32'd0};
        vecs[7]  = '{"sll",      32'h80000001, 32'd0,        enc_r(1, 2, 3, 4, 0),          32'h00000010};
        vecs[8]  = '{"srl",      32'h80000000, 32'd0,        enc_r(1, 2, 3, 31, 2),         32'd1};
        vecs[9]  = '{"addi_neg", 32'd10,       32'd0,        enc_i(8, 1, 3, 16'hFFFD),      32'd7};
        vecs[10] = '{"andi_zx",  32'hFFFFFFFF, 32'd0,        enc_i(12, 1, 3, 16'h8001),     32'h00008001};
        vecs[11] = '{"ori_zx",   32'h12340000, 32'd0,        enc_i(13, 1, 3, 16'hABCD),     32'h1234ABCD};
        vecs[12] = '{"lui",      32'd0,        32'd0,        enc_i(36, 3, 0, 16'hBEEF),     32'hBEEF0000};
        vecs[13] = '{"bad_op",   32'd1,        32'd2,        enc_i(6'h3F, 3, 3, 16'h1234),  32'd0};
        vecs[14] = '{"bad_fn",   32'd1,        32'd2,        enc_r(1, 2, 3, 0, 63),         32'd0};

        rst = 1'b0; a = '0; d = '0; we = 1'b0; exec = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset state
        do_reset();
        check32("rst_pc", 32'(dut.r_pc), 32'd0);
        check32("rst_outs", out1 | out2 | out3 | out4, 32'd0);

        // Single-instruction vectors, operands built with lui/ori
        for (int v = 0; v < 15; v++) begin
            do_reset();
            prog.delete();
            prog.push_back(enc_i(36, 1, 0, vecs[v].va[31:16]));
            prog.push_back(enc_i(13, 1, 1, vecs[v].va[15:0]));
            prog.push_back(enc_i(36, 2, 0, vecs[v].vb[31:16]));
            prog.push_back(enc_i(13, 2, 2, vecs[v].vb[15:0]));
            prog.push_back(vecs[v].instr);
            load_prog();
            run(8);
            check32({"vec_", vecs[v].name}, dut.r_regs[3], vecs[v].exp);
            check32({"vec_pc_", vecs[v].name}, 32'(dut.r_pc), 32'd5);
        end

        // addi -1, lui, halt
        do_reset();
        prog.delete();
        prog.push_back(enc_i(8, 0, 1, 16'hFFFF));
        prog.push_back(enc_i(36, 19, 0, 16'h1234));
        prog.push_back(32'h0);
        load_prog();
        run(5);
        check32("addi_m1", dut.r_regs[1], 32'hFFFFFFFF);
        check32("lui_out1", out1, 32'h12340000);
        check32("halt_pc", 32'(dut.r_pc), 32'd2);

        // bgte not taken / taken at PC 20, ble signed
        for (int t = 0; t < 2; t++) begin
            do_reset();
            prog.delete();
            prog.push_back(enc_i(8, 0, 1, (t == 0) ? 16'd1 : 16'd4));
            prog.push_back(enc_i(8, 0, 2, 16'd4));
            prog.push_back(enc_j(20));
            for (int i = 0; i < 17; i++) prog.push_back(32'h0);
            prog.push_back(enc_i(6'h33, 1, 2, 16'd21));
            load_prog();
            run(7);
            check32((t == 0) ? "bgte_nt" : "bgte_t", 32'(dut.r_pc), (t == 0) ? 32'd21 : 32'd42);
        end
        do_reset();
        prog.delete();
        prog.push_back(enc_i(8, 0, 1, 16'hFFFF));
        prog.push_back(enc_i(6'h32, 1, 0, 16'd5));
        load_prog();
        run(5);
        check32("ble_signed", 32'(dut.r_pc), 32'd7);

        // $0 stays zero
        do_reset();
        prog.delete();
        prog.push_back(enc_i(8, 0, 1, 16'd7));
        prog.push_back(enc_i(8, 0, 0, 16'd5));
        prog.push_back(enc_r(0, 1, 19, 0, 32));
        load_prog();
        run(5);
        check32("r0_zero", dut.r_regs[0], 32'd0);
        check32("r0_add", out1, 32'd7);

        // Insertion sort with pauses and ignored load noise
        do_reset();
        build_sort();
        load_prog();
        run_noisy("sort", 3000);
        check32("sort_out1", out1, 32'd3);
        check32("sort_out2", out2, 32'd5);
        check32("sort_out3", out3, 32'd7);
        check32("sort_out4", out4, 32'd9);
        check32("sort_pc", 32'(dut.r_pc), 32'd46);
        run(5);
        check32("sort_stable", {out1 ^ 32'd3} | {out2 ^ 32'd5} | {out3 ^ 32'd7} | {out4 ^ 32'd9}, 32'd0);
        check32("sort_pc_hold", 32'(dut.r_pc), 32'd46);
        #2 rst = 1'b1;
        #1 check32("rst_after_sort", out1 | out2 | out3 | out4, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset in the middle of the sort
        do_reset();
        build_sort();
        load_prog();
        run(60);
        check_state("pre_rst_mid");
        #2 rst = 1'b1;
        #1;
        check32("rst_mid_pc", 32'(dut.r_pc), 32'd0);
        check32("rst_mid_reg2", dut.r_regs[2], 32'd0);
        check32("rst_mid_dmem", dut.r_dmem[13], 32'd0);
        model_reset();
        @(negedge clk);
        exec = 1'b1;
        tick();
        check32("rst_hold_pc", 32'(dut.r_pc), 32'd0);
        check32("rst_hold_reg1", dut.r_regs[1], 32'd0);
        rst = 1'b0;
        exec = 1'b0;

        // Random programs against the model
        for (int p = 0; p < 6; p++) begin
            do_reset();
            prog.delete();
            for (int i = 0; i < 24; i++) begin
                case ($urandom_range(0, 6))
                    0: prog.push_back(enc_r(rr(), rr(), rr(), 5'($urandom_range(0, 31)), fnset[$urandom_range(0, 7)]));
                    1: prog.push_back(enc_i(($urandom_range(0, 2) == 0) ? 6'd8 : (($urandom_range(0, 1) == 0) ? 6'd12 : 6'd13),
                                            rr(), rr(), 16'($urandom)));
                    2: prog.push_back(enc_i(36, rr(), 0, 16'($urandom)));
                    3: prog.push_back(enc_i(($urandom_range(0, 1) == 0) ? 6'd35 : 6'd43, rr(), rr(),
                                            16'($urandom_range(0, 40))));
                    4: prog.push_back(enc_i(6'(6'h32 + $urandom_range(0, 2)), rr(), rr(), 16'($urandom_range(0, 3))));
                    5: prog.push_back(enc_j(26'(i + 1 + $urandom_range(0, 3))));
                    default: prog.push_back(enc_i(6'h3F, rr(), rr(), 16'($urandom)));
                endcase
            end
            load_prog();
            run_noisy($sformatf("rand%0d", p), 300);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
